// File: rtl/line_buffer_pkg.sv
// Shared definitions for the line buffer and its feeder actor: field widths,
// header layout and the per-flux context state.
package line_buffer_pkg;

  localparam int unsigned SIZE_WIDTH   = 7;
  localparam int unsigned DATA_WIDTH   = 18;
  localparam int unsigned MAX_LINE     = 64;
  localparam int unsigned REMAIN_WIDTH = 2 * SIZE_WIDTH;

  // Header layout: {tag, ext_h, real_w}
  localparam int unsigned HDR_REAL_W_LSB = 0;
  localparam int unsigned HDR_EXT_H_LSB  = SIZE_WIDTH;
  localparam int unsigned HDR_TAG_LSB    = 2 * SIZE_WIDTH;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } flux_state_e;

  // A single flux still needs a one-bit tag field.
  function automatic int unsigned tag_width(input int unsigned flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

endpackage

// File: rtl/line_buffer_feeder_if.sv
// Tagged multi-flux FIFO interfaces: per-flux flags and strobes, per-flux read
// data heads, one shared write data bus tagged with the target flux.
interface read_interface #(
  parameter int unsigned FLUX  = 2,
  parameter int unsigned WIDTH = 8
);
  logic [FLUX-1:0]            empty;
  logic [FLUX-1:0]            read;
  logic [FLUX-1:0][WIDTH-1:0] dout;

  modport actor (input empty, input dout, output read);
  modport fifo  (output empty, output dout, input read);
endinterface

interface write_interface #(
  parameter int unsigned FLUX  = 2,
  parameter int unsigned WIDTH = 8
);
  logic [FLUX-1:0]  full;
  logic [FLUX-1:0]  write;
  logic [WIDTH-1:0] din;

  modport actor (input full, output write, output din);
  modport fifo  (output full, input write, input din);
endinterface

// File: rtl/line_buffer_feeder_flux_prio_sel.sv
// Lowest-index-wins priority encoder over per-flux eligibility bits; shared by
// multi-flux actors to pick the single action that fires each cycle.
module flux_prio_sel #(
  parameter int unsigned FLUX      = 2,
  parameter int unsigned TAG_WIDTH = 1
) (
  input  logic [FLUX-1:0]      elig,
  output logic [TAG_WIDTH-1:0] tag,
  output logic                 valid
);

  // Scan from the top so the lowest eligible index is the last one written.
  always_comb begin
    tag   = '0;
    valid = 1'b0;
    for (int i = int'(FLUX) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        tag   = TAG_WIDTH'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_buffer_feeder.sv
// Dataflow actor feeding line_buffer: per flux, turns a block header into
// ext_size/real_size tokens and forwards real_w*ext_h tagged pels.
module line_buffer_feeder
  import line_buffer_pkg::*;
#(
  parameter int unsigned FLUX = 2
) (
  input  logic             clk,
  input  logic             rst,
  read_interface.actor     read_port_blk_hdr,
  read_interface.actor     read_port_pel_in,
  write_interface.actor    write_port_ext_size,
  write_interface.actor    write_port_real_size,
  write_interface.actor    write_port_out_pel,
  output logic [FLUX-1:0]  err_size
);

  localparam int unsigned TAG_WIDTH = tag_width(FLUX);
  localparam int unsigned HDR_WIDTH = 2 * SIZE_WIDTH + TAG_WIDTH;
  localparam int unsigned PEL_WIDTH = DATA_WIDTH + TAG_WIDTH;
  localparam logic [SIZE_WIDTH-1:0] MaxRealW = SIZE_WIDTH'(MAX_LINE);

  flux_state_e             state_q  [FLUX];
  flux_state_e             state_d  [FLUX];
  logic [REMAIN_WIDTH-1:0] remain_q [FLUX];
  logic [REMAIN_WIDTH-1:0] remain_d [FLUX];
  logic [FLUX-1:0]         err_q, err_d;

  logic [FLUX-1:0]         hdr_en, pel_en, sel_oh;
  logic [TAG_WIDTH-1:0]    sel;
  logic                    sel_valid;
  logic                    fire_hdr, fire_pel;

  logic [HDR_WIDTH-1:0]    hdr_word;
  logic [PEL_WIDTH-1:0]    pel_word;
  logic [SIZE_WIDTH-1:0]   hdr_ext_h, hdr_real_w;
  logic [DATA_WIDTH-1:0]   pel_data;
  logic                    hdr_legal;
  logic [REMAIN_WIDTH-1:0] blk_pels;
  logic                    unused_tags;

  // HDR needs both size FIFOs free so the two size tokens always travel together.
  always_comb begin
    hdr_en = '0;
    pel_en = '0;
    for (int f = 0; f < int'(FLUX); f++) begin
      hdr_en[f] = (state_q[f] == IDLE) && !read_port_blk_hdr.empty[f] &&
                  !write_port_ext_size.full[f] && !write_port_real_size.full[f];
      pel_en[f] = (state_q[f] == STREAM) && !read_port_pel_in.empty[f] &&
                  !write_port_out_pel.full[f];
    end
  end

  flux_prio_sel #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_prio_sel (
    .elig  (hdr_en | pel_en),
    .tag   (sel),
    .valid (sel_valid)
  );

  // Gating by rst keeps every strobe low for the whole reset window.
  assign fire_hdr = rst && sel_valid && (state_q[sel] == IDLE);
  assign fire_pel = rst && sel_valid && (state_q[sel] == STREAM);
  assign sel_oh   = FLUX'(1) << sel;

  assign hdr_word   = read_port_blk_hdr.dout[sel];
  assign pel_word   = read_port_pel_in.dout[sel];
  assign hdr_ext_h  = hdr_word[HDR_EXT_H_LSB +: SIZE_WIDTH];
  assign hdr_real_w = hdr_word[HDR_REAL_W_LSB +: SIZE_WIDTH];
  assign pel_data   = pel_word[DATA_WIDTH-1:0];

  assign hdr_legal = (hdr_real_w != '0) && (hdr_real_w <= MaxRealW) && (hdr_ext_h != '0);
  assign blk_pels  = REMAIN_WIDTH'(hdr_real_w) * REMAIN_WIDTH'(hdr_ext_h);

  // Incoming tags are implied by the FIFO lane; the output tag is the selected flux.
  assign unused_tags = ^{hdr_word[HDR_TAG_LSB +: TAG_WIDTH], pel_word[DATA_WIDTH +: TAG_WIDTH]};

  assign read_port_blk_hdr.read     = fire_hdr ? sel_oh : '0;
  assign write_port_ext_size.write  = (fire_hdr && hdr_legal) ? sel_oh : '0;
  assign write_port_real_size.write = (fire_hdr && hdr_legal) ? sel_oh : '0;
  assign read_port_pel_in.read      = fire_pel ? sel_oh : '0;
  assign write_port_out_pel.write   = fire_pel ? sel_oh : '0;

  assign write_port_ext_size.din  = {sel, hdr_ext_h};
  assign write_port_real_size.din = {sel, hdr_real_w};
  assign write_port_out_pel.din   = {sel, pel_data};

  always_comb begin
    for (int f = 0; f < int'(FLUX); f++) begin
      state_d[f]  = state_q[f];
      remain_d[f] = remain_q[f];
    end
    err_d = err_q;

    if (fire_hdr) begin
      if (hdr_legal) begin
        state_d[sel]  = STREAM;
        remain_d[sel] = blk_pels;
      end else begin
        err_d[sel] = 1'b1;
      end
    end

    if (fire_pel) begin
      remain_d[sel] = remain_q[sel] - REMAIN_WIDTH'(1);
      if (remain_q[sel] == REMAIN_WIDTH'(1)) begin
        state_d[sel] = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < int'(FLUX); f++) begin
        state_q[f]  <= IDLE;
        remain_q[f] <= '0;
      end
      err_q <= '0;
    end else begin
      for (int f = 0; f < int'(FLUX); f++) begin
        state_q[f]  <= state_d[f];
        remain_q[f] <= remain_d[f];
      end
      err_q <= err_d;
    end
  end

  assign err_size = err_q;

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Directed bench for line_buffer_feeder: behavioural FIFOs around the actor,
// a table of header/block vectors, then hand-written multi-cycle sequences.
module tb_line_buffer_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] err_size;
  logic [1:0] ext_full  = 2'b00;
  logic [1:0] real_full = 2'b00;
  logic [1:0] out_full  = 2'b00;

  always #5 clk = ~clk;

  read_interface  #(.FLUX(2), .WIDTH(15)) blk_hdr_if ();
  read_interface  #(.FLUX(2), .WIDTH(19)) pel_in_if ();
  write_interface #(.FLUX(2), .WIDTH(8))  ext_if ();
  write_interface #(.FLUX(2), .WIDTH(8))  real_if ();
  write_interface #(.FLUX(2), .WIDTH(19)) out_if ();

  line_buffer_feeder #(.FLUX(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .read_port_blk_hdr    (blk_hdr_if),
    .read_port_pel_in     (pel_in_if),
    .write_port_ext_size  (ext_if),
    .write_port_real_size (real_if),
    .write_port_out_pel   (out_if),
    .err_size             (err_size)
  );

  // Input FIFO models: write pointers owned by stimulus, read pointers by the monitor.
  logic [14:0] hdr_mem [2][256];
  logic [18:0] pel_mem [2][1024];
  int hdr_wp [2];
  int hdr_rp [2];
  int pel_wp [2];
  int pel_rp [2];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    assign blk_hdr_if.empty[g] = (hdr_wp[g] == hdr_rp[g]);
    assign blk_hdr_if.dout[g]  = hdr_mem[g][hdr_rp[g][7:0]];
    assign pel_in_if.empty[g]  = (pel_wp[g] == pel_rp[g]);
    assign pel_in_if.dout[g]   = pel_mem[g][pel_rp[g][9:0]];
  end
  assign ext_if.full  = ext_full;
  assign real_if.full = real_full;
  assign out_if.full  = out_full;

  typedef struct {
    int          cyc;
    logic [18:0] data;
  } rec_t;

  rec_t ext_log  [$];
  rec_t real_log [$];
  rec_t out_log  [$];

  int cyc = 0;
  int last_act = 0;
  int proto_err = 0;

  logic [1:0]  lat_hdr_rd, lat_pel_rd, lat_ext_wr, lat_real_wr, lat_out_wr;
  logic [7:0]  lat_ext_din, lat_real_din;
  logic [18:0] lat_out_din;

  // Sample strobes mid-cycle; stimulus only moves just after posedge.
  always @(negedge clk) begin
    lat_hdr_rd   = blk_hdr_if.read;
    lat_pel_rd   = pel_in_if.read;
    lat_ext_wr   = ext_if.write;
    lat_real_wr  = real_if.write;
    lat_out_wr   = out_if.write;
    lat_ext_din  = ext_if.din;
    lat_real_din = real_if.din;
    lat_out_din  = out_if.din;
    if ((blk_hdr_if.read & blk_hdr_if.empty) != 0 || (pel_in_if.read & pel_in_if.empty) != 0 ||
        (ext_if.write & ext_if.full) != 0 || (real_if.write & real_if.full) != 0 ||
        (out_if.write & out_if.full) != 0) proto_err++;
    if (ext_if.write != real_if.write) proto_err++;
    if (ext_if.write != 0 && ext_if.write != blk_hdr_if.read) proto_err++;
    if (out_if.write != pel_in_if.read) proto_err++;
    if (blk_hdr_if.read != 0 && pel_in_if.read != 0) proto_err++;
    if ($countones(blk_hdr_if.read) > 1 || $countones(pel_in_if.read) > 1) proto_err++;
    if (ext_if.write != 0 && ext_if.write != (2'b01 << ext_if.din[7])) proto_err++;
    if (real_if.write != 0 && real_if.write != (2'b01 << real_if.din[7])) proto_err++;
    if (out_if.write != 0 && out_if.write != (2'b01 << out_if.din[18])) proto_err++;
    if (out_if.write != 0 && out_if.din[17:0] != pel_in_if.dout[out_if.din[18]][17:0])
      proto_err++;
  end

  always @(posedge clk) begin
    for (int f = 0; f < 2; f++) begin
      if (lat_hdr_rd[f]) hdr_rp[f] <= hdr_rp[f] + 1;
      if (lat_pel_rd[f]) pel_rp[f] <= pel_rp[f] + 1;
    end
    if (lat_ext_wr != 0)  ext_log.push_back('{cyc, {11'd0, lat_ext_din}});
    if (lat_real_wr != 0) real_log.push_back('{cyc, {11'd0, lat_real_din}});
    if (lat_out_wr != 0)  out_log.push_back('{cyc, lat_out_din});
    if ((lat_hdr_rd | lat_pel_rd) != 0) last_act = cyc;
    cyc = cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_hdr(input int f, input int ext_h, input int real_w);
    logic [6:0] e, r;
    e = 7'(ext_h);
    r = 7'(real_w);
    hdr_mem[f][hdr_wp[f][7:0]] = {f[0], e, r};
    hdr_wp[f]++;
  endtask

  task automatic push_pels(input int f, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      pel_mem[f][pel_wp[f][9:0]] = {f[0], 18'(base + i)};
      pel_wp[f]++;
    end
  endtask

  task automatic run_until_quiet(input string name, input int max);
    int n = 0;
    while ((cyc - last_act) < 4 && n < max) begin
      tick(1);
      n++;
    end
    check({name, "_quiet"}, 32'((cyc - last_act) >= 4), 32'd1);
  endtask

  typedef struct {
    int f;
    int ext_h;
    int real_w;
    int base;
    int n;
    bit err;
  } vec_t;

  vec_t vecs [8];
  logic [1:0] err_exp;

  initial begin : main
    int e0, r0, o0, rp_hold, o1, n_t0, n_t1, wait_n;
    string nm;

    vecs[0] = '{0, 3,  4, 'h00000, 12, 1'b0};
    vecs[1] = '{1, 2,  5, 'h00100, 10, 1'b0};
    vecs[2] = '{0, 1, 64, 'h00200, 64, 1'b0};
    vecs[3] = '{1, 1,  1, 'h3ffff,  1, 1'b0};
    vecs[4] = '{0, 3,  0, 'h00000,  0, 1'b1};
    vecs[5] = '{0, 2, 65, 'h00000,  0, 1'b1};
    vecs[6] = '{1, 0,  4, 'h00000,  0, 1'b1};
    vecs[7] = '{0, 2,  3, 'h2a000,  6, 1'b0};

    // Reset holds strobes low even with a header and pel waiting.
    push_hdr(1, 1, 1);
    push_pels(1, 'h1234, 1);
    tick(2);
    check("rst_hdr_read", 32'(blk_hdr_if.read), 32'd0);
    check("rst_err_size", 32'(err_size), 32'd0);
    check("rst_hdr_held", 32'(hdr_rp[1]), 32'(hdr_wp[1] - 1));
    rst = 1'b1;
    o0 = out_log.size();
    tick(2);
    run_until_quiet("pre", 50);
    check("pre_out_cnt", 32'(out_log.size() - o0), 32'd1);
    if (out_log.size() > o0) check("pre_out_data", 32'(out_log[o0].data), 32'h41234);

    err_exp = 2'b00;
    for (int v = 0; v < 8; v++) begin
      e0 = ext_log.size();
      r0 = real_log.size();
      o0 = out_log.size();
      push_hdr(vecs[v].f, vecs[v].ext_h, vecs[v].real_w);
      push_pels(vecs[v].f, vecs[v].base, vecs[v].n);
      tick(2);
      nm = $sformatf("vec%0d", v);
      run_until_quiet(nm, 300);
      check({nm, "_hdr_used"}, 32'(hdr_rp[vecs[v].f]), 32'(hdr_wp[vecs[v].f]));
      check({nm, "_pels_used"}, 32'(pel_rp[vecs[v].f]), 32'(pel_wp[vecs[v].f]));
      check({nm, "_ext_cnt"}, 32'(ext_log.size() - e0), vecs[v].err ? 32'd0 : 32'd1);
      check({nm, "_real_cnt"}, 32'(real_log.size() - r0), vecs[v].err ? 32'd0 : 32'd1);
      check({nm, "_out_cnt"}, 32'(out_log.size() - o0), 32'(vecs[v].n));
      if (ext_log.size() > e0 && real_log.size() > r0) begin
        check({nm, "_ext_tok"}, 32'(ext_log[e0].data), 32'((vecs[v].f << 7) | vecs[v].ext_h));
        check({nm, "_real_tok"}, 32'(real_log[r0].data),
              32'((vecs[v].f << 7) | vecs[v].real_w));
        check({nm, "_size_same_cyc"}, 32'(real_log[r0].cyc), 32'(ext_log[e0].cyc));
        for (int i = 0; i < vecs[v].n && (o0 + i) < out_log.size(); i++) begin
          check($sformatf("%s_pel%0d", nm, i), 32'(out_log[o0 + i].data),
                32'((vecs[v].f << 18) | (vecs[v].base + i)));
          check($sformatf("%s_pel%0d_cyc", nm, i), 32'(out_log[o0 + i].cyc),
                32'(ext_log[e0].cyc + 1 + i));
        end
      end
      if (vecs[v].err) err_exp[vecs[v].f] = 1'b1;
      check({nm, "_err_size"}, 32'(err_size), 32'(err_exp));
    end

    // Both fluxes ready: flux 0 owns the actor until its block ends.
    e0 = ext_log.size();
    o0 = out_log.size();
    push_hdr(0, 2, 3);
    push_pels(0, 'h300, 6);
    push_hdr(1, 1, 4);
    push_pels(1, 'h400, 4);
    tick(2);
    run_until_quiet("arb", 100);
    check("arb_ext_cnt", 32'(ext_log.size() - e0), 32'd2);
    check("arb_out_cnt", 32'(out_log.size() - o0), 32'd10);
    if (ext_log.size() - e0 == 2 && out_log.size() - o0 == 10) begin
      check("arb_ext0", 32'(ext_log[e0].data), 32'h002);
      check("arb_ext1", 32'(ext_log[e0 + 1].data), 32'h081);
      for (int i = 0; i < 10; i++)
        check($sformatf("arb_pel%0d", i), 32'(out_log[o0 + i].data),
              (i < 6) ? 32'('h300 + i) : 32'((1 << 18) | ('h400 + i - 6)));
      check("arb_f1_hdr_cyc", 32'(ext_log[e0 + 1].cyc), 32'(out_log[o0 + 5].cyc + 1));
    end

    // Stall flux 0 output for 5 cycles; flux 1 runs a whole block meanwhile.
    o0 = out_log.size();
    push_hdr(0, 1, 8);
    push_pels(0, 'h500, 8);
    push_hdr(1, 1, 3);
    push_pels(1, 'h600, 3);
    wait_n = 0;
    while (out_log.size() < o0 + 2 && wait_n < 50) begin
      tick(1);
      wait_n++;
    end
    check("bp_started", 32'(out_log.size() - o0), 32'd2);
    out_full = 2'b01;
    rp_hold = pel_rp[0];
    o1 = out_log.size();
    tick(5);
    check("bp_f0_no_read", 32'(pel_rp[0]), 32'(rp_hold));
    n_t0 = 0;
    n_t1 = 0;
    for (int i = o1; i < out_log.size(); i++)
      if (out_log[i].data[18]) n_t1++; else n_t0++;
    check("bp_f0_no_write", 32'(n_t0), 32'd0);
    check("bp_f1_pels", 32'(n_t1), 32'd3);
    out_full = 2'b00;
    tick(2);
    run_until_quiet("bp", 100);
    n_t0 = 0;
    for (int i = o0; i < out_log.size(); i++) begin
      if (!out_log[i].data[18]) begin
        check($sformatf("bp_f0_pel%0d", n_t0), 32'(out_log[i].data), 32'('h500 + n_t0));
        n_t0++;
      end
    end
    check("bp_f0_total", 32'(n_t0), 32'd8);

    // real_size full on flux 1 alone blocks the header.
    e0 = ext_log.size();
    r0 = real_log.size();
    o0 = out_log.size();
    real_full = 2'b10;
    push_hdr(1, 1, 2);
    push_pels(1, 'h700, 2);
    tick(1);
    check("rf_ext_strobe", 32'(ext_if.write), 32'd0);
    check("rf_hdr_strobe", 32'(blk_hdr_if.read), 32'd0);
    tick(3);
    check("rf_hdr_held", 32'(hdr_rp[1]), 32'(hdr_wp[1] - 1));
    check("rf_no_ext", 32'(ext_log.size() - e0), 32'd0);
    real_full = 2'b00;
    tick(2);
    run_until_quiet("rf", 50);
    check("rf_ext_cnt", 32'(ext_log.size() - e0), 32'd1);
    check("rf_real_cnt", 32'(real_log.size() - r0), 32'd1);
    if (ext_log.size() > e0 && real_log.size() > r0)
      check("rf_same_cyc", 32'(real_log[r0].cyc), 32'(ext_log[e0].cyc));
    check("rf_out_cnt", 32'(out_log.size() - o0), 32'd2);

    // Reset after 5 of 16 pels: block abandoned, leftovers stay queued.
    o0 = out_log.size();
    push_hdr(0, 4, 4);
    push_pels(0, 'h800, 16);
    wait_n = 0;
    while (out_log.size() < o0 + 5 && wait_n < 50) begin
      tick(1);
      wait_n++;
    end
    check("rs_before_err", 32'(err_size), 32'(err_exp));
    rst = 1'b0;
    #1;
    check("rs_out_strobe", 32'(out_if.write), 32'd0);
    check("rs_pel_strobe", 32'(pel_in_if.read), 32'd0);
    check("rs_err_clear", 32'(err_size), 32'd0);
    tick(2);
    check("rs_leftover", 32'(pel_wp[0] - pel_rp[0]), 32'd11);
    rst = 1'b1;
    e0 = ext_log.size();
    o0 = out_log.size();
    push_hdr(0, 2, 3);
    tick(2);
    run_until_quiet("rs", 50);
    check("rs_ext_tok", (ext_log.size() > e0) ? 32'(ext_log[e0].data) : 32'hdead, 32'h002);
    check("rs_out_cnt", 32'(out_log.size() - o0), 32'd6);
    for (int i = 0; i < 6 && (o0 + i) < out_log.size(); i++)
      check($sformatf("rs_pel%0d", i), 32'(out_log[o0 + i].data), 32'('h805 + i));

    // Idle flux leaves queued pels alone.
    rp_hold = pel_rp[0];
    tick(6);
    check("idle_no_read", 32'(pel_rp[0]), 32'(rp_hold));
    check("idle_err_size", 32'(err_size), 32'd0);

    check("protocol", 32'(proto_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/line_buffer_feeder.md
# line_buffer_feeder

Dataflow actor that produces the token streams consumed by the HEVC line buffer. Per flux, it reads a block header and a raw pel stream. For each header it emits one ext_size token and one real_size token, then forwards exactly real_w × ext_h pels tagged with the flux index. It sits between the block-partition stage and `line_buffer`, connected through the standard tagged FIFO interfaces.

## Interface
- FLUX, 2, number of interleaved data fluxes; TAG_WIDTH = $clog2(FLUX)
- DATA_WIDTH, 18, pel width excluding tag
- SIZE_WIDTH, 7, width of each size field and of ext_size/real_size tokens
- MAX_LINE, 64, largest legal real_w (line buffer depth)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- read_port_blk_hdr  read_interface.actor  2·SIZE_WIDTH+TAG_WIDTH  header {tag, ext_h[13:7], real_w[6:0]}
- read_port_pel_in  read_interface.actor  DATA_WIDTH+TAG_WIDTH  raw pels {tag, pel}
- write_port_ext_size  write_interface.actor  SIZE_WIDTH+TAG_WIDTH  {tag, ext_h}
- write_port_real_size  write_interface.actor  SIZE_WIDTH+TAG_WIDTH  {tag, real_w}
- write_port_out_pel  write_interface.actor  DATA_WIDTH+TAG_WIDTH  {tag, pel} to line buffer in_pel
- err_size  out  FLUX  sticky per-flux flag: illegal header seen

## Operation
- Per-flux context: state (IDLE/STREAM), remain[13:0] = pels left in the current block.
- Actions per flux f, highest first:
  - HDR: state=IDLE, blk_hdr.empty[f]=0, ext_size.full[f]=0, real_size.full[f]=0.
    - Consume the header.
    - If legal (1 ≤ real_w ≤ MAX_LINE, ext_h ≥ 1): write both size tokens, set remain = real_w·ext_h (unsigned 7×7 → 14 bit), go to STREAM.
    - If illegal: write nothing, set err_size[f], stay IDLE.
  - PEL: state=STREAM, pel_in.empty[f]=0, out_pel.full[f]=0.
    - Read one pel, write {f, pel}, decrement remain.
    - If remain==1, go to IDLE (remain becomes 0).
- Arbitration: the lowest-index flux with an enabled action fires. At most one action fires per cycle across all fluxes.
- read[]/write for unselected fluxes are 0. When nothing fires, all read and write strobes are 0 and din is don't-care.
- The pel payload passes through unmodified. The tag in din always equals the selected flux.
- Pels arriving on pel_in while flux f is IDLE are not read; they wait in the FIFO.

## Timing
- Actor-style firing: read strobes, write strobes and din are combinational from the current state and FIFO flags in the same cycle. Context updates at the next posedge. Latency input→output is 0 cycles.
- Throughput: one token transfer (header or pel) per cycle aggregate.
- A block of N pels occupies N+1 firings of its flux (1 HDR + N PEL).
- Reset (rst=0, async): all states IDLE, remain=0, err_size=0.
  - Strobes go to 0 immediately.
  - A block interrupted mid-stream is abandoned; any remaining pels of it stay in the input FIFO.
- Full/empty: an action never fires with its destination full or its source empty. HDR requires BOTH size FIFOs non-full, so ext_size and real_size are always written together.
- err_size clears only on reset.

## Structure
- Package `line_buffer_pkg`, shared with line_buffer: SIZE_WIDTH, DATA_WIDTH, MAX_LINE, header field offsets, and `typedef enum logic {IDLE, STREAM}`.
- Sub-module `flux_prio_sel`: parameterised FLUX-bit lowest-index priority encoder. Inputs are eligibility bits; outputs are tag and a valid bit. It is reusable by other multi-flux actors.
- The remaining logic (context array, action decode, strobe demux) stays in one module.

## Test plan
- FLUX=2, flux 0 header ext_h=3, real_w=4, 12 pels 0..11 → ext_size {0,3} and real_size {0,4} written in the same cycle, then 12 out_pel tokens {0,0}..{0,11} on 12 consecutive cycles, then IDLE.
- Both fluxes have a header and pels ready → flux 0 fires every cycle until its block finishes or stalls. Flux 1 fires only when flux 0 is blocked. Tags are never mixed.
- Flux 0 streaming with out_pel.full[0]=1 for 5 cycles → no pel_in read, remain unchanged. Flux 1 proceeds if ready.
- Header real_w=0, then real_w=65, then ext_h=0 → each is consumed, err_size[f]=1, and no size tokens or pels are moved. A following legal header streams normally.
- real_size.full[1]=1 with ext_size not full → no header read and no ext_size write until real_size frees.
- rst pulsed low after 5 of 16 pels → outputs idle immediately, err_size=0. A new header restarts cleanly with count real_w·ext_h.
